uart_transmitter: RTL

Serialises bytes from the UART TX byte FIFO in the hardware register block onto the UART TXD pin as 8N1 frames, LSB first. It sits directly downstream of that FIFO: its not_empty output drives tx_valid, and its read_data drives tx_data. The transmitter pulses tx_complete once per finished frame; this pulse is the FIFO's read_enable and pops the sent byte.

---
 rtl/uart_transmitter_if.sv | 21 ++
 rtl/uart_transmitter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/uart_transmitter_if.sv
// Byte handshake between the UART TX byte FIFO and the transmitter.
// The FIFO side is the master. It presents not_empty on tx_valid and the
// head byte on tx_data. The transmitter side is the slave. It returns the
// one-cycle tx_complete pulse, which the FIFO uses as read_enable.
interface uart_transmitter_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_complete;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_complete
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_complete
  );
endinterface : uart_transmitter_if

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises bytes from the TX byte FIFO onto uart_txd.
// Default framing is 8N1 with the LSB first. Each bit lasts CLKS_PER_BIT
// clock cycles.
// Optional feature macro UART_TX_PARITY_EN: when this macro is defined, an
// even-parity bit is inserted between the data bits and the stop bit,
// which gives 8E1 framing.
// All outputs are registered. A reset mid-frame aborts the frame at once.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 434  // legal range 2..65535
) (
  input  logic                  clock,
  input  logic                  reset,
  uart_transmitter_if.slave     tx_bus,
  output logic                  uart_txd,
  output logic                  busy
);

  localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BAUD_TC = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              tx_complete_q;
  logic              baud_tc;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  assign baud_tc            = (baud_cnt == BAUD_TC);
  assign tx_bus.tx_complete = tx_complete_q;

  // Frame sequencer. Every output is registered in this one process, so
  // uart_txd, busy and tx_complete can only change on a clock edge or on reset.
  // NOTE: all state here uses non-blocking assignments. Each register sees
  // the values from the previous edge, whatever the statement order is.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      uart_txd      <= 1'b1;
      busy          <= 1'b0;
      tx_complete_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit    <= 1'b0;
`endif
    end else begin
      tx_complete_q <= 1'b0;

      case (state)
        IDLE: begin
          uart_txd <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          // The cycle that follows tx_complete is where the FIFO pops. Its
          // valid/data still show the byte just sent, so they are ignored.
          if (tx_bus.tx_valid && !tx_complete_q) begin
            shift_reg  <= tx_bus.tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_bus.tx_data;
`endif
            uart_txd   <= 1'b0;
            busy       <= 1'b1;
            state      <= START;
          end
        end

        START: begin
          if (baud_tc) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            uart_txd  <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
            state     <= DATA;
          end else begin
            baud_cnt  <= baud_cnt + CNT_ONE;
          end
        end

        DATA: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              uart_txd <= parity_bit;
              state    <= PARITY;
`else
              uart_txd <= 1'b1;
              state    <= STOP;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              uart_txd  <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        PARITY: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            uart_txd <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        STOP: begin
          if (baud_tc) begin
            baud_cnt      <= '0;
            tx_complete_q <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        default: begin
          baud_cnt <= '0;
          uart_txd <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule : uart_transmitter
